// File: rtl/spi_frame_pkg.sv
// Shared constants, state encoding and byte helpers for the SPI frame arbiter.
// Exports NREQ, FRAME_LEN, HDR_TAG, state_t, build_hdr() and sel_byte().
package spi_frame_pkg;

  localparam int NREQ = 4;
  localparam int FRAME_LEN = 10;
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_FIN,
    ST_ABORT
  } state_t;

  function automatic logic [7:0] build_hdr(
    input logic [3:0] tag,
    input logic [1:0] src
  );
    return {tag, 2'b00, src};
  endfunction

  // idx 0 = header, 1..8 = payload MSB first, 9 = checksum
  function automatic logic [7:0] sel_byte(
    input logic [7:0]  hdr,
    input logic [63:0] pay,
    input logic [7:0]  csum,
    input logic [3:0]  idx
  );
    logic [7:0]  b;
    logic [63:0] sft;
    sft = pay << {idx - 4'd1, 3'b000};
    b = csum;
    unique case (1'b1)
      idx == 4'd0:                b = hdr;
      idx >= 4'd1 && idx <= 4'd8: b = sft[63:56];
      default:                    b = csum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_frame_arb_rr_arbiter.sv
// Combinational 4-way round-robin arbiter: first set req at or after ptr.
// Ports: req[3:0], ptr[1:0] in; one-hot grant[3:0], idx[1:0] out.
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic [1:0] k;

  // scan from farthest to nearest so the nearest hit overwrites
  always_comb begin
    grant = '0;
    idx   = '0;
    k     = '0;
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/spi_frame_arb.sv
// Round-robin frame arbiter feeding a byte-wide SPI transmitter.
// Ports: req/req_data in, ack out; data_send/byte_start/send8b_done to tx;
// spi_start_flag/spi_end_flag/busy status; err_clr in, timeout_err out.
module spi_frame_arb #(
  parameter int         NREQ        = spi_frame_pkg::NREQ,
  parameter int         TIMEOUT_CYC = 4096,
  parameter logic [3:0] HDR_TAG     = spi_frame_pkg::HDR_TAG
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [64*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [7:0]         data_send,
  output logic               byte_start,
  input  logic               send8b_done,
  output logic               spi_start_flag,
  output logic               spi_end_flag,
  output logic               busy,
  input  logic               err_clr,
  output logic               timeout_err
);

  import spi_frame_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  state_t      st, nx;
  logic [1:0]  ptr, src, gidx;
  logic [3:0]  grant;
  logic [3:0]  cnt;
  logic [TW-1:0] tcnt;
  logic [63:0] pay;
  logic [7:0]  dq, hdr, csum, cur_byte;
  logic        d0, d1, done_pulse, last, terr;

  rr_arbiter u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign done_pulse = d0 & ~d1;
  assign last       = (cnt == 4'(FRAME_LEN - 1));
  assign hdr        = build_hdr(HDR_TAG, src);

  // checksum comes only from the latched frame, never live req_data
  always_comb begin
    csum = hdr;
    for (int i = 0; i < 8; i++) csum = csum ^ pay[8*i +: 8];
  end

  assign cur_byte = sel_byte(hdr, pay, csum, cnt);

  always_comb begin
    nx = st;
    unique case (st)
      ST_IDLE:  if (|req) nx = ST_ARB;
      ST_ARB:   nx = (|grant) ? ST_LOAD : ST_IDLE;
      ST_LOAD:  nx = ST_SEND;
      ST_SEND:  nx = ST_WAIT;
      ST_WAIT: begin
        // a done edge on the terminal cycle beats the timeout
        if (done_pulse)       nx = last ? ST_FIN : ST_SEND;
        else if (tcnt == TMAX) nx = ST_ABORT;
      end
      ST_FIN:   nx = ST_IDLE;
      ST_ABORT: nx = ST_IDLE;
      default:  nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      ptr  <= '0;
      src  <= '0;
      cnt  <= '0;
      tcnt <= '0;
      pay  <= '0;
      dq   <= '0;
      d0   <= 1'b0;
      d1   <= 1'b0;
      terr <= 1'b0;
    end else begin
      st <= nx;
      d0 <= send8b_done;
      d1 <= d0;
      unique case (st)
        ST_ARB:  src <= gidx;
        ST_LOAD: begin
          pay <= req_data[{src, 6'd0} +: 64];
          cnt <= '0;
        end
        ST_SEND: begin
          dq   <= cur_byte;
          tcnt <= '0;
        end
        ST_WAIT: begin
          if (done_pulse) begin
            if (!last) cnt <= cnt + 4'd1;
          end else if (tcnt != TMAX) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_FIN:   ptr <= src + 2'd1;
        ST_ABORT: ptr <= src + 2'd1;
        default: ;
      endcase
      // a new abort outranks a clear in the same cycle
      if (st == ST_ABORT) terr <= 1'b1;
      else if (err_clr)   terr <= 1'b0;
    end
  end

  assign busy           = (st != ST_IDLE);
  assign byte_start     = (st == ST_SEND);
  assign spi_start_flag = (st == ST_LOAD);
  assign spi_end_flag   = (st == ST_FIN);
  assign ack            = (st == ST_FIN) ? (NREQ'(1) << src) : '0;
  assign data_send      = byte_start ? cur_byte : dq;
  assign timeout_err    = terr;

endmodule

// File: tb/tb_spi_frame_arb.sv
// Self-checking bench for spi_frame_arb with a frame-level reference model.
// Drives random requests/payloads and an emulated byte transmitter.
module tb_spi_frame_arb;

  localparam int TO = 16;
  localparam logic [3:0] TAG = 4'hA;

  logic         sys_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         send8b_done = 1'b0;
  logic         err_clr = 1'b0;
  logic [3:0]   req = '0;
  logic [255:0] req_data = '0;
  logic [3:0]   ack;
  logic [7:0]   data_send;
  logic         byte_start, spi_start_flag, spi_end_flag;
  logic         busy, timeout_err;

  int total = 0, bad = 0;
  int cyc = 0, bs_cyc = 0, err_cyc = 0;
  int n_start = 0, n_end = 0, n_fall = 0;
  logic prev_busy = 1'b0, prev_err = 1'b0;
  logic [7:0] got[$];
  logic [3:0] ack_log[$];
  int done_lat = 5, stall_byte = -1, stall_lat = 0;
  bit   manual = 1'b0;
  logic manual_val = 1'b0;
  int   mptr = 0;

  spi_frame_arb #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_data       (req_data),
    .ack            (ack),
    .data_send      (data_send),
    .byte_start     (byte_start),
    .send8b_done    (send8b_done),
    .spi_start_flag (spi_start_flag),
    .spi_end_flag   (spi_end_flag),
    .busy           (busy),
    .err_clr        (err_clr),
    .timeout_err    (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  // observer
  initial forever begin
    @(posedge sys_clk);
    #1;
    cyc++;
    if (byte_start) begin
      got.push_back(data_send);
      bs_cyc = cyc;
    end
    if (spi_start_flag) n_start++;
    if (spi_end_flag) n_end++;
    if (ack != 4'd0) ack_log.push_back(ack);
    if (prev_busy && !busy) n_fall++;
    if (timeout_err && !prev_err) err_cyc = cyc;
    prev_busy = busy;
    prev_err  = timeout_err;
  end

  // transmitter: done rises 'lat' cycles after byte_start, 0 = never
  initial begin : tx
    int cd, bn;
    cd = 0;
    bn = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (manual) send8b_done = manual_val;
      else if (!rst_n) begin
        cd = 0;
        send8b_done = 1'b0;
      end else begin
        if (spi_start_flag) bn = 0;
        if (byte_start) begin
          send8b_done = 1'b0;
          cd = (bn == stall_byte) ? stall_lat : done_lat;
          bn++;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) send8b_done = 1'b1;
        end
      end
    end
  end

  function automatic logic [79:0] mframe(int s, logic [63:0] p);
    logic [7:0] h, c;
    h = {TAG, 2'b00, 2'(s)};
    c = h;
    for (int i = 0; i < 8; i++) c ^= p[8*i +: 8];
    return {h, p, c};
  endfunction

  function automatic int mpick(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  function automatic logic [79:0] got_frame();
    logic [79:0] f;
    f = '0;
    foreach (got[i]) f = {f[71:0], got[i]};
    return f;
  endfunction

  task automatic wait_done(output bit to);
    int k;
    k = n_fall;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge sys_clk);
      #2;
      if (n_fall != k) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic clr_logs();
    got.delete();
    ack_log.delete();
  endtask

  task automatic test_reset();
    logic [16:0] ov;
    rst_n = 1'b0;
    req = '0;
    err_clr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    ov = {ack, data_send, byte_start, spi_start_flag,
          spi_end_flag, busy, timeout_err};
    total++;
    if (ov !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", ov);
    end
    rst_n = 1'b1;
    mptr = 0;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic serve(string nm, logic [63:0] p[4]);
    int s;
    bit to;
    s = mpick(req, mptr);
    clr_logs();
    wait_done(to);
    total++;
    if ({to, 8'(got.size()), got_frame()} !==
        {1'b0, 8'd10, mframe(s, p[s])}) begin
      bad++;
      $display("FAIL %s_frame src=%0d got=%h want=%h",
               nm, s, got_frame(), mframe(s, p[s]));
    end
    total++;
    if (ack_log.size() != 1 || ack_log[0] !== 4'(1 << s)) begin
      bad++;
      $display("FAIL %s_ack n=%0d want=%b",
               nm, ack_log.size(), 4'(1 << s));
    end
    mptr = (s + 1) % 4;
  endtask

  task automatic load_pay(output logic [63:0] p[4]);
    for (int i = 0; i < 4; i++) begin
      p[i] = {$urandom, $urandom};
      req_data[64*i +: 64] = p[i];
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] p[4];
    load_pay(p);
    done_lat = 5;
    req = 4'hF;
    for (int f = 0; f < 5; f++) serve("rr", p);
    req = '0;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_single();
    logic [63:0] p[4];
    int s0, e0;
    load_pay(p);
    p[0] = 64'h0123456789ABCDEF;
    req_data[63:0] = p[0];
    s0 = n_start;
    e0 = n_end;
    req = 4'b0001;
    serve("single", p);
    req = '0;
    total++;
    if ({n_start - s0, n_end - e0} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL single_flags start=%0d end=%0d want=1,1",
               n_start - s0, n_end - e0);
    end
  endtask

  task automatic test_random();
    logic [63:0] p[4];
    int s;
    for (int it = 0; it < 6; it++) begin
      load_pay(p);
      done_lat = $urandom_range(2, 9);
      req = 4'($urandom_range(1, 15));
      while (req != 4'd0) begin
        s = mpick(req, mptr);
        serve("rand", p);
        req[s] = 1'b0;
      end
      @(posedge sys_clk);
      #2;
    end
    done_lat = 5;
  endtask

  task automatic test_timeout();
    logic [63:0] p[4];
    logic [79:0] gf, ex;
    int a, b, s;
    bit to;
    load_pay(p);
    a = $urandom_range(0, 3);
    b = (a + $urandom_range(1, 3)) % 4;
    req = 4'((1 << a) | (1 << b));
    stall_byte = 3;
    stall_lat = 0;
    s = mpick(req, mptr);
    clr_logs();
    begin
      int e0;
      e0 = n_end;
      wait_done(to);
      gf = got_frame();
      ex = mframe(s, p[s]);
      total++;
      if ({to, 8'(got.size()), gf[31:0]} !==
          {1'b0, 8'd4, ex[79:48]}) begin
        bad++;
        $display("FAIL to_partial got=%h want=%h", gf[31:0], ex[79:48]);
      end
      total++;
      if ({ack_log.size() != 0, n_end != e0, timeout_err} !== 3'b001) begin
        bad++;
        $display("FAIL to_flags acks=%0d ends=%0d err=%b want 0,0,1",
                 ack_log.size(), n_end - e0, timeout_err);
      end
    end
    // terminal wait cycle TO after byte_start, then ABORT, then flag
    total++;
    if (err_cyc - bs_cyc != TO + 2) begin
      bad++;
      $display("FAIL to_latency got=%0d want=%0d", err_cyc - bs_cyc, TO + 2);
    end
    stall_byte = -1;
    mptr = (s + 1) % 4;
    for (int f = 0; f < 2; f++) begin
      s = mpick(req, mptr);
      serve("to_next", p);
      req[s] = 1'b0;
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky got=%b want=1", timeout_err);
    end
  endtask

  task automatic test_err_clr();
    logic [63:0] p[4];
    int a;
    bit to;
    err_clr = 1'b1;
    @(posedge sys_clk);
    #2;
    err_clr = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr got=%b want=0", timeout_err);
    end
    load_pay(p);
    a = $urandom_range(0, 3);
    err_clr = 1'b1;
    stall_byte = 3;
    stall_lat = 0;
    req = 4'(1 << a);
    clr_logs();
    wait_done(to);
    req = '0;
    total++;
    if ({to, timeout_err} !== 2'b01) begin
      bad++;
      $display("FAIL err_set_wins to=%b got=%b want=1", to, timeout_err);
    end
    @(posedge sys_clk);
    #2;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr_held got=%b want=0", timeout_err);
    end
    err_clr = 1'b0;
    stall_byte = -1;
    mptr = (a + 1) % 4;
  endtask

  task automatic test_done_vs_timeout();
    logic [63:0] p[4];
    int a;
    bit to;
    load_pay(p);
    a = $urandom_range(0, 3);
    stall_byte = 3;
    stall_lat = TO - 1;
    req = 4'(1 << a);
    serve("edge_win", p);
    req = '0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL edge_win_err got=%b want=0", timeout_err);
    end
    @(posedge sys_clk);
    #2;
    a = $urandom_range(0, 3);
    stall_lat = TO;
    req = 4'(1 << a);
    clr_logs();
    wait_done(to);
    req = '0;
    total++;
    if ({to, timeout_err, 8'(got.size()), 8'(ack_log.size())} !==
        {1'b0, 1'b1, 8'd4, 8'd0}) begin
      bad++;
      $display("FAIL edge_late err=%b bytes=%0d acks=%0d want 1,4,0",
               timeout_err, got.size(), ack_log.size());
    end
    mptr = (a + 1) % 4;
    stall_byte = -1;
    err_clr = 1'b1;
    @(posedge sys_clk);
    #2;
    err_clr = 1'b0;
  endtask

  task automatic test_stray_done();
    logic [63:0] p[4];
    int nb;
    nb = 0;
    clr_logs();
    manual = 1'b1;
    manual_val = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2;
    manual_val = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      #2;
      nb += int'(busy);
    end
    manual_val = 1'b0;
    repeat (3) begin
      @(posedge sys_clk);
      #2;
      nb += int'(busy);
    end
    manual = 1'b0;
    total++;
    if (nb != 0 || got.size() != 0) begin
      bad++;
      $display("FAIL stray_idle busy=%0d bytes=%0d want 0,0",
               nb, got.size());
    end
    load_pay(p);
    req = 4'(1 << $urandom_range(0, 3));
    serve("stray_next", p);
    req = '0;
  endtask

  task automatic test_dropped_req();
    logic [63:0] p[4];
    int a, k;
    bit to;
    load_pay(p);
    a = $urandom_range(0, 3);
    done_lat = 4;
    req = 4'(1 << a);
    clr_logs();
    k = 0;
    while (got.size() < 3 && k < 200) begin
      @(posedge sys_clk);
      #2;
      k++;
    end
    req = '0;
    req_data = {8{$urandom}};
    wait_done(to);
    total++;
    if ({to, 8'(got.size()), got_frame()} !==
        {1'b0, 8'd10, mframe(a, p[a])}) begin
      bad++;
      $display("FAIL drop_frame got=%h want=%h",
               got_frame(), mframe(a, p[a]));
    end
    total++;
    if (ack_log.size() != 1 || ack_log[0] !== 4'(1 << a)) begin
      bad++;
      $display("FAIL drop_ack n=%0d want=%b", ack_log.size(), 4'(1 << a));
    end
    mptr = (a + 1) % 4;
    done_lat = 5;
  endtask

  task automatic test_mid_reset();
    logic [63:0] p[4];
    logic [16:0] ov;
    int k;
    load_pay(p);
    req = 4'b0001;
    clr_logs();
    k = 0;
    while (got.size() < 6 && k < 300) begin
      @(posedge sys_clk);
      #2;
      k++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    ov = {ack, data_send, byte_start, spi_start_flag,
          spi_end_flag, busy, timeout_err};
    total++;
    if (k >= 300 || ov !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h want=0 k=%0d", ov, k);
    end
    req = 4'b0100;
    load_pay(p);
    repeat (2) @(posedge sys_clk);
    #2;
    clr_logs();
    mptr = 0;
    rst_n = 1'b1;
    serve("post_reset", p);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_random();
    test_timeout();
    test_err_clr();
    test_done_vs_timeout();
    test_stray_done();
    test_dropped_req();
    test_mid_reset();
    repeat (3) @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
